// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the CPU memory bus arbiter: requester indices, FSM state encoding.
// Global bus widths fall back to 16-bit address / 8-bit data when not already defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package mem_bus_arbiter_pkg;

    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int REG_W  = `REG_WIDTH;

    localparam int REQ_F = 0;
    localparam int REQ_E = 1;
    localparam int REQ_D = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_F = 2'd1,
        ARB_OWN_E = 2'd2,
        ARB_OWN_D = 2'd3
    } arb_state_t;

    function automatic arb_state_t gnt_state(input logic [2:0] gnt);
        arb_state_t s;
        s = ARB_IDLE;
        if (gnt[REQ_D])      s = ARB_OWN_D;
        else if (gnt[REQ_E]) s = ARB_OWN_E;
        else if (gnt[REQ_F]) s = ARB_OWN_F;
        return s;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester/memory bundle around the arbiter; slave = arbiter side, master = requesters + memory.
interface mem_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] addr_f;
    logic [AW-1:0] addr_e;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_e;
    logic [DW-1:0] wdata_d;
    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req, we, addr_f, addr_e, addr_d, wdata_e, wdata_d, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr_f, addr_e, addr_d, wdata_e, wdata_d, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter_arb_prio_pick.sv
// Combinational masked fixed-priority picker, dma > exec > fetch; one-hot or zero out.
module arb_prio_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [2:0] i_mask,
    output logic [2:0] o_gnt
);
    logic [2:0] w_req;

    assign w_req = i_req & i_mask;

    always_comb begin
        o_gnt = 3'b000;
        if (w_req[REQ_D])      o_gnt[REQ_D] = 1'b1;
        else if (w_req[REQ_E]) o_gnt[REQ_E] = 1'b1;
        else if (w_req[REQ_F]) o_gnt[REQ_F] = 1'b1;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Single owner of the CPU memory bus: registered one-hot grant, hold-limit preemption,
// combinational memory strobes from the current owner, read data returned one cycle later.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int REG_WIDTH  = `REG_WIDTH,
    parameter int MAX_HOLD   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_bus_arbiter_if.slave  bus
);
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    arb_state_t            r_state;
    logic [2:0]            r_gnt;
    logic [2:0]            r_rvalid;
    logic [HW-1:0]         r_hold_cnt;

    logic                  w_access;
    logic                  w_others;
    logic                  w_expired;
    logic                  w_keep;
    logic [2:0]            w_mask;
    logic [2:0]            w_pick;
    logic [2:0]            w_next_gnt;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [REG_WIDTH-1:0]  w_wdata;

    assign w_access  = |(r_gnt & bus.req);
    assign w_others  = |(bus.req & ~r_gnt);
    assign w_expired = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST) && w_others;
    assign w_keep    = w_access && !w_expired;
    // An expired owner sits out exactly one decision so a waiter can take over.
    assign w_mask    = w_expired ? ~r_gnt : 3'b111;

    arb_prio_pick u_pick (
        .i_req  (bus.req),
        .i_mask (w_mask),
        .o_gnt  (w_pick)
    );

    assign w_next_gnt = w_keep ? r_gnt : w_pick;

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        case (r_state)
            ARB_OWN_F: w_addr = bus.addr_f;
            ARB_OWN_E: begin
                w_addr  = bus.addr_e;
                w_wdata = bus.wdata_e;
                w_we    = bus.we[REQ_E];
            end
            ARB_OWN_D: begin
                w_addr  = bus.addr_d;
                w_wdata = bus.wdata_d;
                w_we    = bus.we[REQ_D];
            end
            default: ;
        endcase
    end

    assign bus.mem_en    = w_access;
    assign bus.mem_we    = w_access & w_we;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = (|r_rvalid) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= 3'b000;
            r_rvalid   <= 3'b000;
            r_hold_cnt <= '0;
        end else begin
            r_state  <= gnt_state(w_next_gnt);
            r_gnt    <= w_next_gnt;
            // Tag follows the requester that issued the read, even if the bus moves on.
            r_rvalid <= (w_access && !w_we) ? r_gnt : 3'b000;
            if ((w_next_gnt != r_gnt) || (w_next_gnt == 3'b000)) begin
                r_hold_cnt <= '0;
            end else if (w_access && (r_hold_cnt != HOLD_LAST)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end
endmodule
